// File: rtl/pc_update_ras_if.sv
// Bus between the fetch/execute side and the next-PC register: control and operand inputs,
// registered PC, status and return-address-stack outputs.
interface pc_update_ras_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned CNT_W  = 16
);
    logic              en;
    logic [3:0]        icode;
    logic              cnd;
    logic [ADDR_W-1:0] valP;
    logic [ADDR_W-1:0] valC;
    logic [ADDR_W-1:0] valM;
    logic [ADDR_W-1:0] pc;
    logic [1:0]        status;
    logic              ras_hit;
    logic              ras_miss;
    logic              ras_ovf;
    logic [CNT_W-1:0]  miss_cnt;

    modport master (
        output en, icode, cnd, valP, valC, valM,
        input  pc, status, ras_hit, ras_miss, ras_ovf, miss_cnt
    );

    modport slave (
        input  en, icode, cnd, valP, valC, valM,
        output pc, status, ras_hit, ras_miss, ras_ovf, miss_cnt
    );
endinterface

// File: rtl/pc_update_ras.sv
// Y86-64 next-PC register with sticky RUN/HALT/ERR status and stall enable.
// Define PC_UPDATE_RAS_EN to add the return-address-stack checker (hit/miss/overflow/miss count).
module pc_update_ras #(
    parameter int unsigned       ADDR_W    = 64,
    parameter int unsigned       RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int unsigned       CNT_W     = 16
) (
    input logic            clk,
    input logic            rst_n,
    pc_update_ras_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic              w_adv;

    assign w_adv = bus.en && (r_state == ST_RUN);

    // Next-PC selection and status transitions; halt/invalid codes freeze the PC
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        if (w_adv) begin
            case (bus.icode)
                4'h0:    w_state_nxt = ST_HALT;
                4'h7:    w_pc_nxt    = bus.cnd ? bus.valC : bus.valP;
                4'h8:    w_pc_nxt    = bus.valC;
                4'h9:    w_pc_nxt    = bus.valM;
                4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB:
                         w_pc_nxt    = bus.valP;
                default: w_state_nxt = ST_ERR;
            endcase
        end else begin
            w_state_nxt = r_state;
            w_pc_nxt    = r_pc;
        end
    end

    // PC and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    assign bus.pc     = r_pc;
    assign bus.status = r_state;

`ifdef PC_UPDATE_RAS_EN
    localparam int unsigned     PTR_W   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [PTR_W:0]  DEPTH_C = (PTR_W + 1)'(RAS_DEPTH);

    logic [ADDR_W-1:0] r_ras [RAS_DEPTH];
    logic [PTR_W-1:0]  r_tp;
    logic [PTR_W:0]    r_cnt;
    logic              r_hit;
    logic              r_miss;
    logic              r_ovf;
    logic [CNT_W-1:0]  r_miss_cnt;

    logic              w_call;
    logic              w_ret;
    logic              w_empty;
    logic              w_full;
    logic              w_match;
    logic              w_miss_ev;
    logic [PTR_W-1:0]  w_tp_inc;

    assign w_call    = w_adv && (bus.icode == 4'h8);
    assign w_ret     = w_adv && (bus.icode == 4'h9);
    assign w_empty   = (r_cnt == {(PTR_W + 1){1'b0}});
    assign w_full    = (r_cnt == DEPTH_C);
    assign w_match   = (r_ras[r_tp] == bus.valM);
    assign w_miss_ev = w_ret && (w_empty || !w_match);
    assign w_tp_inc  = r_tp + PTR_W'(1);

    // Stack storage; contents after reset are irrelevant because cnt gates every read
    always_ff @(posedge clk) begin
        if (w_call) begin
            r_ras[w_tp_inc] <= bus.valP;
        end
    end

    // Pointer, occupancy, pulse, sticky overflow and saturating miss counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tp       <= '0;
            r_cnt      <= '0;
            r_hit      <= 1'b0;
            r_miss     <= 1'b0;
            r_ovf      <= 1'b0;
            r_miss_cnt <= '0;
        end else begin
            r_hit  <= 1'b0;
            r_miss <= 1'b0;
            if (w_call) begin
                r_tp <= w_tp_inc;
                if (w_full) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + (PTR_W + 1)'(1);
                end
            end else if (w_ret) begin
                if (w_empty) begin
                    r_miss <= 1'b1;
                end else begin
                    r_hit  <= w_match;
                    r_miss <= !w_match;
                    r_tp   <= r_tp - PTR_W'(1);
                    r_cnt  <= r_cnt - (PTR_W + 1)'(1);
                end
            end
            if (w_miss_ev && (r_miss_cnt != {CNT_W{1'b1}})) begin
                r_miss_cnt <= r_miss_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.ras_hit  = r_hit;
    assign bus.ras_miss = r_miss;
    assign bus.ras_ovf  = r_ovf;
    assign bus.miss_cnt = r_miss_cnt;
`else
    localparam int unsigned UNUSED_RAS_DEPTH = RAS_DEPTH;

    assign bus.ras_hit  = 1'b0;
    assign bus.ras_miss = 1'b0;
    assign bus.ras_ovf  = 1'b0;
    assign bus.miss_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_update_ras.sv
// Scoreboard bench for pc_update_ras: a behavioural model pushes expected outputs per edge,
// each scenario task pops and compares after the edge.
`timescale 1ns/1ps
module tb_pc_update_ras;
`ifdef PC_UPDATE_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif
    localparam logic [63:0] RST_PC = 64'h100;
    localparam int          DEPTH  = 8;

    typedef struct packed {
        logic [63:0] pc;
        logic [1:0]  status;
        logic        hit;
        logic        miss;
        logic        ovf;
        logic [15:0] mc;
    } obs_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [63:0] m_pc;
    logic [1:0]  m_status;
    logic        m_ovf;
    logic [15:0] m_mc;
    logic [63:0] m_stack [$];
    obs_t        sb_q [$];

    pc_update_ras_if #(.ADDR_W(64), .CNT_W(16)) bus ();

    pc_update_ras #(
        .ADDR_W(64), .RAS_DEPTH(DEPTH), .RESET_PC(RST_PC), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t observe();
        return {bus.pc, bus.status, bus.ras_hit, bus.ras_miss, bus.ras_ovf, bus.miss_cnt};
    endfunction

    function automatic string fmt(obs_t x);
        return $sformatf("pc=%h st=%0d hit=%b miss=%b ovf=%b mc=%0d",
                         x.pc, x.status, x.hit, x.miss, x.ovf, x.mc);
    endfunction

    task automatic model_reset();
        m_pc = RST_PC; m_status = 2'd0; m_ovf = 1'b0; m_mc = 16'd0;
        m_stack.delete();
        sb_q.delete();
    endtask

    task automatic do_reset();
        bus.en = 1'b0;
        rst_n  = 1'b0;
        model_reset();
        #3;
        rst_n = 1'b1;
    endtask

    // Drive one cycle, predict the outputs after the edge, push the prediction.
    task automatic drive(input logic en, input logic [3:0] ic, input logic c,
                         input logic [63:0] p, input logic [63:0] vc, input logic [63:0] vm);
        logic        hit;
        logic        miss;
        logic [63:0] top;
        bus.en = en; bus.icode = ic; bus.cnd = c; bus.valP = p; bus.valC = vc; bus.valM = vm;
        hit = 1'b0; miss = 1'b0;
        if (en && m_status == 2'd0) begin
            case (ic)
                4'h0: m_status = 2'd1;
                4'h7: m_pc = c ? vc : p;
                4'h8: begin
                    m_pc = vc;
                    if (RAS_ON) begin
                        if (m_stack.size() == DEPTH) begin
                            void'(m_stack.pop_front());
                            m_ovf = 1'b1;
                        end
                        m_stack.push_back(p);
                    end
                end
                4'h9: begin
                    m_pc = vm;
                    if (RAS_ON) begin
                        if (m_stack.size() == 0) miss = 1'b1;
                        else begin
                            top = m_stack.pop_back();
                            if (top == vm) hit = 1'b1;
                            else miss = 1'b1;
                        end
                        if (miss && m_mc != 16'hFFFF) m_mc = m_mc + 16'd1;
                    end
                end
                4'hC, 4'hD, 4'hE, 4'hF: m_status = 2'd2;
                default: m_pc = p;
            endcase
        end
        sb_q.push_back({m_pc, m_status, hit, miss, m_ovf, m_mc});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t e, o;
        rst_n = 1'b1; bus.en = 1'b0; bus.icode = 4'h1; bus.cnd = 1'b0;
        bus.valP = 64'h0; bus.valC = 64'h0; bus.valM = 64'h0;
        #1;
        rst_n = 1'b0;
        model_reset();
        #2;
        e = {RST_PC, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0}; o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL reset_async: got %s, expected %s", fmt(o), fmt(e)); end
        @(posedge clk); #1;
        o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL reset_held: got %s, expected %s", fmt(o), fmt(e)); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        obs_t e, o;
        drive(1'b1, 4'h1, 1'b0, 64'h0A, 64'h0, 64'h0);
        e = sb_q.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL basic_valp: got %s, expected %s", fmt(o), fmt(e)); end
    endtask

    task automatic test_jxx();
        obs_t e, o;
        drive(1'b1, 4'h7, 1'b1, 64'h0B, 64'h40, 64'h0);
        e = sb_q.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL jxx_taken: got %s, expected %s", fmt(o), fmt(e)); end
        drive(1'b1, 4'h7, 1'b0, 64'h49, 64'h77, 64'h0);
        e = sb_q.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL jxx_not_taken: got %s, expected %s", fmt(o), fmt(e)); end
        drive(1'b0, 4'h7, 1'b1, 64'h99, 64'h98, 64'h0);
        e = sb_q.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL jxx_stall: got %s, expected %s", fmt(o), fmt(e)); end
    endtask

    task automatic test_call_ret();
        obs_t e, o;
        drive(1'b1, 4'h8, 1'b0, 64'h13, 64'h80, 64'h0);
        e = sb_q.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL call: got %s, expected %s", fmt(o), fmt(e)); end
        drive(1'b1, 4'h9, 1'b0, 64'h81, 64'h0, 64'h13);
        e = sb_q.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL ret_hit: got %s, expected %s", fmt(o), fmt(e)); end
        drive(1'b1, 4'h2, 1'b0, 64'h15, 64'h0, 64'h13);
        e = sb_q.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL hit_pulse_end: got %s, expected %s", fmt(o), fmt(e)); end
    endtask

    task automatic test_underflow_mismatch();
        obs_t e, o;
        drive(1'b1, 4'h9, 1'b0, 64'h16, 64'h0, 64'h20);
        e = sb_q.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL ret_underflow: got %s, expected %s", fmt(o), fmt(e)); end
        drive(1'b1, 4'h8, 1'b0, 64'h30, 64'h50, 64'h0);
        e = sb_q.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL call_mm: got %s, expected %s", fmt(o), fmt(e)); end
        drive(1'b1, 4'h9, 1'b0, 64'h51, 64'h0, 64'h31);
        e = sb_q.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL ret_mismatch: got %s, expected %s", fmt(o), fmt(e)); end
    endtask

    task automatic test_overflow();
        obs_t e, o;
        for (int i = 1; i <= 9; i++) begin
            drive(1'b1, 4'h8, 1'b0, 64'(i), 64'(32'h200 + i), 64'h0);
            e = sb_q.pop_front(); o = observe(); checks++;
            if (o !== e) begin errors++; $display("FAIL ovf_call%0d: got %s, expected %s", i, fmt(o), fmt(e)); end
        end
        for (int i = 9; i >= 1; i--) begin
            drive(1'b1, 4'h9, 1'b0, 64'h0, 64'h0, 64'(i));
            e = sb_q.pop_front(); o = observe(); checks++;
            if (o !== e) begin errors++; $display("FAIL ovf_ret%0d: got %s, expected %s", i, fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_stall_ras();
        obs_t e, o;
        do_reset();
        drive(1'b0, 4'h8, 1'b0, 64'h60, 64'h61, 64'h0);
        e = sb_q.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL stall_call: got %s, expected %s", fmt(o), fmt(e)); end
        drive(1'b1, 4'h9, 1'b0, 64'h0, 64'h0, 64'h60);
        e = sb_q.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL stall_no_push: got %s, expected %s", fmt(o), fmt(e)); end
        drive(1'b0, 4'h9, 1'b0, 64'h0, 64'h0, 64'h66);
        e = sb_q.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL stall_ret: got %s, expected %s", fmt(o), fmt(e)); end
    endtask

    task automatic test_status();
        obs_t e, o;
        do_reset();
        drive(1'b1, 4'h1, 1'b0, 64'h44, 64'h0, 64'h0);
        void'(sb_q.pop_front());
        drive(1'b1, 4'h0, 1'b0, 64'h45, 64'h0, 64'h0);
        e = sb_q.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL halt: got %s, expected %s", fmt(o), fmt(e)); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'h1, 1'b0, 64'(32'h55 + i), 64'h0, 64'h0);
            e = sb_q.pop_front(); o = observe(); checks++;
            if (o !== e) begin errors++; $display("FAIL halt_frozen%0d: got %s, expected %s", i, fmt(o), fmt(e)); end
        end
        drive(1'b1, 4'h9, 1'b0, 64'h0, 64'h0, 64'h70);
        e = sb_q.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL halt_no_ras: got %s, expected %s", fmt(o), fmt(e)); end
        do_reset();
        drive(1'b1, 4'hD, 1'b0, 64'h88, 64'h0, 64'h0);
        e = sb_q.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL invalid_err: got %s, expected %s", fmt(o), fmt(e)); end
        drive(1'b1, 4'h8, 1'b0, 64'h89, 64'h90, 64'h0);
        e = sb_q.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL err_sticky: got %s, expected %s", fmt(o), fmt(e)); end
    endtask

    task automatic test_async_reset();
        obs_t e, o;
        do_reset();
        drive(1'b1, 4'h8, 1'b0, 64'h33, 64'h300, 64'h0);
        void'(sb_q.pop_front());
        drive(1'b1, 4'h9, 1'b0, 64'h0, 64'h0, 64'h34);
        e = sb_q.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL pre_reset: got %s, expected %s", fmt(o), fmt(e)); end
        rst_n = 1'b0;
        model_reset();
        sb_q.push_back({m_pc, m_status, 1'b0, 1'b0, m_ovf, m_mc});
        #2;
        e = sb_q.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL midrun_reset: got %s, expected %s", fmt(o), fmt(e)); end
        rst_n = 1'b1;
        drive(1'b1, 4'h3, 1'b0, 64'h123, 64'h0, 64'h0);
        e = sb_q.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL post_reset_run: got %s, expected %s", fmt(o), fmt(e)); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_jxx();
        test_call_ret();
        test_underflow_mismatch();
        test_overflow();
        test_stall_ras();
        test_status();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_update_ras.md
# pc_update_ras

Parametrised next-PC register for the Y86-64 core, successor to the single-cycle PC update stage. It selects the next PC from valP, valC or valM by icode and cnd. It holds a RUN/HALT/ERR status machine, a clock-enable for stalls, and an optional return-address stack (RAS). The RAS checks every `ret` target against the address pushed by the matching `call` and counts mismatches.

## Interface
- ADDR_W, 64, PC/address width (valP, valC, valM, pc, RAS entries)
- RAS_DEPTH, 8, RAS entries; power of two, ≥2
- RESET_PC, 0, PC value loaded on reset
- CNT_W, 16, width of saturating RAS miss counter

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  advance enable; 0 = stall, all state held
- icode  in  4  instruction code of the current instruction
- cnd  in  1  branch condition from execute
- valP  in  ADDR_W  incremented PC
- valC  in  ADDR_W  instruction constant / destination
- valM  in  ADDR_W  value read from memory (return address for ret)
- pc  out  ADDR_W  registered current PC
- status  out  2  0=RUN, 1=HALT, 2=ERR
- ras_hit  out  1  one-cycle pulse: ret target matched RAS top
- ras_miss  out  1  one-cycle pulse: ret target mismatched or RAS empty
- ras_ovf  out  1  sticky: a call overwrote a live entry
- miss_cnt  out  CNT_W  saturating count of ras_miss events

## Operation
- Update happens only on posedge clk with en=1 and status=RUN; otherwise every register holds.
- Next PC by icode:
  - 7 (jXX): cnd ? valC : valP
  - 8 (call): valC
  - 9 (ret): valM
  - 1–6, A, B: valP
- icode 0 (halt): pc holds; status→HALT.
- icode C–F: invalid; pc holds; status→ERR.
- HALT and ERR are sticky. The only exit is rst_n=0.
- RAS is a circular buffer with top pointer `tp` (log2 RAS_DEPTH bits) and occupancy `cnt` (0..RAS_DEPTH).
- call: write valP at tp+1, tp←tp+1, cnt←min(cnt+1, RAS_DEPTH).
  - If cnt was already RAS_DEPTH, the oldest entry is overwritten and ras_ovf←1.
- ret with cnt>0: compare entry[tp] with valM.
  - Equal → ras_hit=1.
  - Unequal → ras_miss=1 and miss_cnt+1.
  - In both cases tp←tp−1, cnt←cnt−1.
- ret with cnt=0: underflow. ras_miss=1, miss_cnt+1; tp and cnt unchanged.
- Pointer arithmetic wraps modulo RAS_DEPTH.
- miss_cnt saturates at 2^CNT_W−1.
- The pc path always uses valM. The RAS only checks; it never redirects.

## Timing
- Reset (async assert, sync-to-clk deassert by the system):
  - pc=RESET_PC, status=RUN
  - tp=0, cnt=0, ras_ovf=0, miss_cnt=0
  - ras_hit=0, ras_miss=0
  - RAS entry contents are don't-care.
- Latency: 1 cycle. Inputs sampled at edge N appear on pc/status at edge N (registered outputs, visible after N).
- ras_hit/ras_miss are high for exactly the one cycle following the ret edge, and 0 on any cycle without an enabled ret.
- en=0 during a call/ret: no push or pop, no pulse.
- rst_n asserted mid-operation clears all state immediately, regardless of clk.
- halt/invalid icodes produce no RAS side effects.

## Configuration
- Macro: PC_UPDATE_RAS_EN.
- Defined: RAS, ras_hit/ras_miss/ras_ovf/miss_cnt logic present as above.
- Undefined: no RAS storage. ras_hit, ras_miss and ras_ovf are tied 0; miss_cnt is tied 0. PC/status behaviour is identical.

## Test plan
- Reset then icode=1 with valP=0x0A, en=1 → pc=0x0A, status=0; with RESET_PC=0x100, pc=0x100 after reset.
- jXX: icode=7, cnd=1, valC=0x40 → pc=0x40; then cnd=0, valP=0x49 → pc=0x49; en=0 on the next edge → pc stays 0x49.
- Matched call/ret: call valC=0x80, valP=0x13; then ret valM=0x13 → pc=0x80 then 0x13, ras_hit one pulse, miss_cnt=0.
- Underflow and mismatch:
  - ret on empty RAS, valM=0x20 → pc=0x20, ras_miss pulse, miss_cnt=1.
  - call (valP=0x30), then ret valM=0x31 → ras_miss, miss_cnt=2.
- Overflow with RAS_DEPTH=8:
  - 9 calls with valP=1..9 → ras_ovf=1.
  - 8 rets with valM=9..2 → 8 ras_hit.
  - 9th ret → ras_miss (underflow).
- Status machine:
  - icode=0 → status=1, pc frozen through 3 further edges of icode=1.
  - After reset, icode=0xD → status=2.
  - rst_n pulsed low mid-run → pc=RESET_PC, status=0, miss_cnt=0 without a clock edge.
